// File: rtl/multicycle_addsub.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH-bit operation, SLICE bits per clock
// through one registered carry, with start/busy/done handshake and carry/overflow/zero flags.
module multicycle_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_reg, b_reg, work, work_next;
  logic             carry;
  logic [CW-1:0]    k;
  logic             last;
  logic [SLICE-1:0] sa, sb;
  logic [SLICE:0]   slice_sum;
  logic             cin_msb;

  // Slice mux/demux uses constant part-selects compared against k.
  always_comb begin
    sa        = '0;
    sb        = '0;
    work_next = work;
    for (int unsigned i = 0; i < N; i++) begin
      if (k == CW'(i)) begin
        sa = a_reg[i*SLICE +: SLICE];
        sb = b_reg[i*SLICE +: SLICE];
      end
    end
    slice_sum = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, carry};
    for (int unsigned i = 0; i < N; i++) begin
      if (k == CW'(i)) work_next[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    end
  end

  // Carry into the slice MSB recovered from the MSB sum bit and its two operand bits.
  assign cin_msb = slice_sum[SLICE-1] ^ sa[SLICE-1] ^ sb[SLICE-1];
  assign last    = (k == CW'(N - 1));
  assign busy    = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      work     <= '0;
      carry    <= 1'b0;
      k        <= '0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
            carry <= sub;
            k     <= '0;
            work  <= '0;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= slice_sum[SLICE];
          k     <= k + 1'b1;
          if (last) begin
            sum      <= work_next;
            carryout <= slice_sum[SLICE];
            overflow <= cin_msb ^ slice_sum[SLICE];
            zero     <= (work_next == '0);
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench for multicycle_addsub: 16/4 and 16/16 instances checked against
// an arithmetic reference model; a monitor per instance pops expectations on done.
module tb_multicycle_addsub;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    logic        z;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, sub0, start1, sub1;
  logic [15:0] a0, b0, a1, b1;
  logic        busy0, done0, co0, ov0, z0;
  logic        busy1, done1, co1, ov1, z1;
  logic [15:0] sum0, sum1;

  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        rst_q;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        l0, l1;

  multicycle_addsub #(.WIDTH(16), .SLICE(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .sub(sub0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .sum(sum0), .carryout(co0), .overflow(ov0), .zero(z0)
  );

  multicycle_addsub #(.WIDTH(16), .SLICE(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carryout(co1), .overflow(ov1), .zero(z1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the unmodified operands.
  function automatic exp_t model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                 input int unsigned due);
    exp_t e;
    int   sr;
    logic [16:0] u;
    if (!s) begin
      u    = {1'b0, x} + {1'b0, y};
      e.co = u[16];
      sr   = int'($signed(x)) + int'($signed(y));
      e.sum = x + y;
    end else begin
      e.co  = (x >= y);
      sr    = int'($signed(x)) - int'($signed(y));
      e.sum = x - y;
    end
    e.ov  = (sr > 32767) || (sr < -32768);
    e.z   = (e.sum == 16'h0000);
    e.due = due;
    return e;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic set_in(input int d, input logic st, input logic s, input logic [15:0] x,
                        input logic [15:0] y);
    if (d == 0) begin start0 = st; sub0 = s; a0 = x; b0 = y; end
    else        begin start1 = st; sub1 = s; a1 = x; b1 = y; end
  endtask

  // Called at a negedge; holds start until the instance is idle, then records the expectation.
  task automatic run(input int d, input logic s, input logic [15:0] x, input logic [15:0] y);
    int unsigned n = 0;
    set_in(d, 1'b1, s, x, y);
    while (busy_of(d) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("accept_timeout", {31'b0, busy_of(d)}, 0);
    else if (d == 0) q0.push_back(model(s, x, y, cyc + 1 + 4));
    else             q1.push_back(model(s, x, y, cyc + 1 + 1));
    @(negedge clk);
  endtask

  task automatic wait_idle(input int d);
    int unsigned n = 0;
    if (d == 0) start0 = 1'b0; else start1 = 1'b0;
    while (qsize(d) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("done_timeout", qsize(d), 0);
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h0001;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (rst_q) begin
        chk("rst_busy0", {31'b0, busy0}, 0);
        chk("rst_done0", {31'b0, done0}, 0);
        chk("rst_flags0", {16'b0, sum0, 13'b0, co0, ov0, z0}, 0);
        q0.delete();
        l0 = '{16'h0, 1'b0, 1'b0, 1'b0, 0};
      end else begin
        chk("busy_done_excl0", {31'b0, busy0 & done0}, 0);
        if (done0) begin
          if (q0.size() == 0) chk("spurious_done0", {31'b0, done0}, 0);
          else begin
            e = q0.pop_front();
            chk("sum0", {16'b0, sum0}, {16'b0, e.sum});
            chk("carryout0", {31'b0, co0}, {31'b0, e.co});
            chk("overflow0", {31'b0, ov0}, {31'b0, e.ov});
            chk("zero0", {31'b0, z0}, {31'b0, e.z});
            chk("latency0", cyc, e.due);
            l0 = e;
          end
        end else begin
          chk("hold0", {16'b0, sum0, 13'b0, co0, ov0, z0}, {16'b0, l0.sum, 13'b0, l0.co, l0.ov, l0.z});
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      if (rst_q) begin
        chk("rst_busy1", {31'b0, busy1}, 0);
        chk("rst_flags1", {16'b0, sum1, 12'b0, done1, co1, ov1, z1}, 0);
        q1.delete();
        l1 = '{16'h0, 1'b0, 1'b0, 1'b0, 0};
      end else begin
        chk("busy_done_excl1", {31'b0, busy1 & done1}, 0);
        if (done1) begin
          if (q1.size() == 0) chk("spurious_done1", {31'b0, done1}, 0);
          else begin
            e = q1.pop_front();
            chk("result1", {12'b0, sum1, co1, ov1, z1}, {12'b0, e.sum, e.co, e.ov, e.z});
            chk("latency1", cyc, e.due);
            l1 = e;
          end
        end else begin
          chk("hold1", {16'b0, sum1, 13'b0, co1, ov1, z1}, {16'b0, l1.sum, 13'b0, l1.co, l1.ov, l1.z});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_in(0, 1'b1, 1'b0, 16'h1234, 16'h1111);
    set_in(1, 1'b1, 1'b0, 16'h1234, 16'h1111);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_in(1, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);

    // Directed corners on the 4-bit-slice instance.
    run(0, 1'b0, 16'h7FFF, 16'h0001); wait_idle(0);
    run(0, 1'b0, 16'hFFFF, 16'h0001); wait_idle(0);
    run(0, 1'b1, 16'h8000, 16'h0001); wait_idle(0);
    run(0, 1'b1, 16'h0000, 16'h8000); wait_idle(0);

    // A start pulse during busy must be dropped.
    run(0, 1'b1, 16'h0003, 16'h0005);
    start0 = 1'b0;
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 16'h1111, 16'h2222);
    @(negedge clk);
    wait_idle(0);

    // Start held high across consecutive operations.
    run(0, 1'b0, 16'h0005, 16'h0006);
    run(0, 1'b1, 16'h0001, 16'h0001);
    run(0, 1'b0, 16'h4000, 16'h4000);
    wait_idle(0);

    // Mid-operation reset: aborted, no done, outputs back to zero.
    run(0, 1'b0, 16'h1234, 16'h4321);
    start0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      run(0, 1'($urandom_range(0, 1)), pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        start0 = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    wait_idle(0);

    // Single-slice instance.
    run(1, 1'b0, 16'h1234, 16'h1111); wait_idle(1);
    for (int i = 0; i < 10; i++) run(1, 1'($urandom_range(0, 1)), pick(), pick());
    wait_idle(1);

    chk("queue_empty0", q0.size(), 0);
    chk("queue_empty1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
